ram_arbiter_2x1: RTL
====================

Name: ram_arbiter_2x1

Overview:
- Shares one 32x4096 synchronous-read RAM between two requesters:
  - port A, instruction fetch, read-only in practice;
  - port B, data load/store.
- Converts each port's waitrequest-style bus into single-cycle RAM commands.
- Absorbs the RAM's one-cycle read latency.
- Arbitrates round-robin; sits in the CPU testbench between the MIPS core and the RAM.

Parameters:
- RAM_AW, 12, RAM word-address width; the RAM holds 2^RAM_AW words.
- RESET_PRIO_A, 1, if 1, port A wins the first arbitration after reset; if 0, port B wins.

Ports:
- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- a_address  in  32  port A byte address
- a_read  in  1  port A read request
- a_write  in  1  port A write request
- a_writedata  in  32  port A write data
- a_waitrequest  out  1  port A stall; low for exactly the completing cycle
- a_readdata  out  32  port A read data, valid when a_waitrequest=0
- b_address, b_read, b_write, b_writedata, b_waitrequest, b_readdata  as port A
- ram_address  out  RAM_AW  RAM word address
- ram_read  out  1  RAM read strobe
- ram_write  out  1  RAM write strobe
- ram_writedata  out  32  RAM write data
- ram_readdata  in  32  RAM data, registered by RAM one cycle after command

Behaviour:
- Port rules:
  - Request = read|write.
  - Requester holds address, data and strobes stable while its waitrequest=1.
  - Requester may change them the cycle after waitrequest=0.
- Address map: RAM word address = address[RAM_AW+1:2]. Bits [1:0] are ignored. Upper bits are ignored, so accesses wrap modulo 4*2^RAM_AW bytes.
- read&write together on a port: treated as a write. readdata returns the pre-write word, because the RAM reads old contents.
- FSM states: IDLE, ISSUE, RESP. Registers: state, grant (A/B), last_grant (A/B).
- IDLE:
  - No request: stay in IDLE.
  - Otherwise: select a winner → ISSUE, grant=winner.
- ISSUE:
  - RAM command registers are driven from the granted port for this cycle.
  - ram_read=read&~write; ram_write=write.
  - → RESP.
- RESP:
  - Granted port sees waitrequest=0 and readdata=ram_readdata.
  - last_grant ← grant.
  - If the other port is requesting: → ISSUE with grant=other.
  - Else: → IDLE.
  - The granted port's request is not re-sampled in RESP; its next request is seen in IDLE at the earliest.
- Winner selection when both ports request: the port ≠ last_grant. Single requester: that port.
- last_grant reset value: B if RESET_PRIO_A=1, A otherwise.
- Latency:
  - Request asserted in IDLE at cycle 0: ISSUE at cycle 1, completion (waitrequest=0) at cycle 2.
  - Back-to-back alternating requests: one completion every 2 cycles.
- RAM outputs:
  - Registered; all zero outside ISSUE.
  - The strobe is active only during ISSUE, exactly one cycle per transaction.
- Port outputs:
  - waitrequest=1 at all times except the grant port's RESP cycle.
  - readdata=0 except the grant port's RESP cycle.
- Reset:
  - Async assertion forces state=IDLE, clears ram_read/ram_write/ram_address/ram_writedata to 0, and sets last_grant to its reset value.
  - Both waitrequests are 1 during reset. Both readdatas are 0.
  - An in-flight ISSUE write is dropped if reset_n falls before its clock edge.
  - An interrupted transaction is never completed. The requester must re-issue.
- Request withdrawn mid-transaction (protocol violation): the transaction completes as latched at ISSUE. No error signalled.

Decomposition:
- Shared package ram_arb_pkg:
  - enum arb_state_t {IDLE, ISSUE, RESP};
  - enum port_t {PORT_A, PORT_B};
  - constant RAM_AW_DEFAULT=12.
- One natural sub-module: rr_pick2. Combinational two-way round-robin pick from (req_a, req_b, last_grant) → (valid, winner).
- FSM and datapath muxes stay in ram_arbiter_2x1.

Test Plan:
- Reset, A only: A reads 0x0000_0010 with RAM word 4 = 0xDEADBEEF.
  - → ram_read=1, ram_address=4 at cycle 1.
  - → a_waitrequest=0, a_readdata=0xDEADBEEF at cycle 2.
  - → b_waitrequest=1 throughout.
- B write then A read of the same word: B writes 0x1234_5678 to 0x0000_0020, then A reads 0x0000_0020.
  - → ram_write=1 with ram_address=8 once.
  - → A later returns 0x12345678.
- Both ports request from reset, both continuously re-requesting:
  - → grant order A, B, A, B.
  - → completions at cycles 2, 4, 6, 8; no port waits more than one other transaction.
- Address wrap and alignment: A reads 0x0000_4003.
  - → ram_address=0.
  - → readdata equals word 0.
- Simultaneous read&write on B to word 3 (old 0xAAAA_AAAA, new 0x5555_5555):
  - → ram_write=1, ram_read=0.
  - → b_readdata=0xAAAAAAAA.
  - → a subsequent read returns 0x55555555.
- reset_n pulsed low during ISSUE of a B write:
  - → ram_write drops immediately; RAM word unchanged.
  - → state IDLE; both waitrequests=1 while in reset.
  - → after release, A wins the first arbitration.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and defaults for the two-port RAM arbiter.
package ram_arb_pkg;
  localparam int RAM_AW_DEFAULT = 12;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;
endpackage

// File: rtl/ram_arbiter_2x1_rr_pick2.sv
// rr_pick2: two-way round-robin pick; on a tie the port that did not win last time goes.
module rr_pick2
  import ram_arb_pkg::*;
(
  input  logic  req_a,
  input  logic  req_b,
  input  port_t last_grant,
  output logic  valid,
  output port_t winner
);
  assign valid  = req_a | req_b;
  assign winner = (req_a && req_b) ? ((last_grant == PORT_A) ? PORT_B : PORT_A)
                                   : (req_a ? PORT_A : PORT_B);
endmodule

// File: rtl/ram_arbiter_2x1.sv
// ram_arbiter_2x1: shares one synchronous-read RAM between two waitrequest-style ports,
// issuing one registered RAM command per transaction and returning data one cycle later.
module ram_arbiter_2x1
  import ram_arb_pkg::*;
#(
  parameter int RAM_AW       = RAM_AW_DEFAULT,
  parameter bit RESET_PRIO_A = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       a_address,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [31:0]       a_writedata,
  output logic              a_waitrequest,
  output logic [31:0]       a_readdata,
  input  logic [31:0]       b_address,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [31:0]       b_writedata,
  output logic              b_waitrequest,
  output logic [31:0]       b_readdata,
  output logic [RAM_AW-1:0] ram_address,
  output logic              ram_read,
  output logic              ram_write,
  output logic [31:0]       ram_writedata,
  input  logic [31:0]       ram_readdata
);
  arb_state_t        state_q, state_d;
  port_t             grant_q, grant_d, last_grant_q, last_grant_d;
  port_t             pick_winner, other, next_port;
  logic              pick_valid, a_req, b_req, other_req, issue;
  logic              sel_read, sel_write, a_done, b_done;
  logic [31:0]       sel_address, sel_writedata;
  logic              unused_addr_bits;
  logic [RAM_AW-1:0] ram_address_q, ram_address_d;
  logic              ram_read_q, ram_read_d, ram_write_q, ram_write_d;
  logic [31:0]       ram_writedata_q, ram_writedata_d;

  assign a_req     = a_read | a_write;
  assign b_req     = b_read | b_write;
  assign other     = (grant_q == PORT_A) ? PORT_B : PORT_A;
  assign other_req = (other == PORT_A) ? a_req : b_req;

  rr_pick2 u_pick (
    .req_a      (a_req),
    .req_b      (b_req),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  // RESP hands straight over to a waiting other port, so alternating traffic completes every 2 cycles
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    issue        = 1'b0;
    next_port    = pick_winner;
    case (state_q)
      IDLE:  issue = pick_valid;
      ISSUE: state_d = RESP;
      RESP: begin
        last_grant_d = grant_q;
        issue        = other_req;
        next_port    = other;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (issue) begin
      state_d = ISSUE;
      grant_d = next_port;
    end
  end

  assign sel_address      = (next_port == PORT_A) ? a_address : b_address;
  assign sel_writedata    = (next_port == PORT_A) ? a_writedata : b_writedata;
  assign sel_read         = (next_port == PORT_A) ? a_read : b_read;
  assign sel_write        = (next_port == PORT_A) ? a_write : b_write;
  assign unused_addr_bits = ^{sel_address[31:RAM_AW+2], sel_address[1:0]};

  // read&write together becomes a write; the RAM still returns the old word
  always_comb begin
    ram_address_d   = issue ? sel_address[RAM_AW+1:2] : '0;
    ram_read_d      = issue & sel_read & ~sel_write;
    ram_write_d     = issue & sel_write;
    ram_writedata_d = issue ? sel_writedata : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      grant_q         <= PORT_A;
      last_grant_q    <= RESET_PRIO_A ? PORT_B : PORT_A;
      ram_address_q   <= '0;
      ram_read_q      <= 1'b0;
      ram_write_q     <= 1'b0;
      ram_writedata_q <= '0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      last_grant_q    <= last_grant_d;
      ram_address_q   <= ram_address_d;
      ram_read_q      <= ram_read_d;
      ram_write_q     <= ram_write_d;
      ram_writedata_q <= ram_writedata_d;
    end
  end

  assign ram_address   = ram_address_q;
  assign ram_read      = ram_read_q;
  assign ram_write     = ram_write_q;
  assign ram_writedata = ram_writedata_q;

  assign a_done        = (state_q == RESP) && (grant_q == PORT_A);
  assign b_done        = (state_q == RESP) && (grant_q == PORT_B);
  assign a_waitrequest = ~a_done;
  assign b_waitrequest = ~b_done;
  assign a_readdata    = a_done ? ram_readdata : '0;
  assign b_readdata    = b_done ? ram_readdata : '0;
endmodule
